// File: rtl/ex_hilo_div_stage.sv
// Execute stage: logic/shift/move ALU, HI/LO registers, 32-cycle divider.
// Feeds the ID forwarding bus combinationally and registers EX/MEM.
module ex_hilo_div_stage #(
   parameter int DIV_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  aluop_i,
   input  logic [2:0]  alusel_i,
   input  logic [31:0] reg1_i,
   input  logic [31:0] reg2_i,
   input  logic [4:0]  wd_i,
   input  logic        wreg_i,
   output logic        fwd_wreg_o,
   output logic [4:0]  fwd_wd_o,
   output logic [31:0] fwd_wdata_o,
   output logic        wreg_o,
   output logic [4:0]  wd_o,
   output logic [31:0] wdata_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        stall_req_o
);

   localparam logic [7:0] OP_AND  = 8'b00100100;
   localparam logic [7:0] OP_OR   = 8'b00100101;
   localparam logic [7:0] OP_XOR  = 8'b00100110;
   localparam logic [7:0] OP_NOR  = 8'b00100111;
   localparam logic [7:0] OP_SLL  = 8'b01111100;
   localparam logic [7:0] OP_SRL  = 8'b00000010;
   localparam logic [7:0] OP_SRA  = 8'b00000011;
   localparam logic [7:0] OP_MFHI = 8'b00010000;
   localparam logic [7:0] OP_MTHI = 8'b00010001;
   localparam logic [7:0] OP_MFLO = 8'b00010010;
   localparam logic [7:0] OP_MTLO = 8'b00010011;
   localparam logic [7:0] OP_DIV  = 8'b00011010;
   localparam logic [7:0] OP_DIVU = 8'b00011011;

   localparam logic [2:0] SEL_LOGIC = 3'b001;
   localparam logic [2:0] SEL_SHIFT = 3'b010;
   localparam logic [2:0] SEL_MOVE  = 3'b011;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_e;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] dvsr_q, dvsr_d;
   logic        negq_q, negq_d;
   logic        negr_q, negr_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        wreg_q;
   logic [4:0]  wd_q;
   logic [31:0] wdata_q;

   logic [31:0] result;
   logic        is_div, is_sdiv, is_mt, stall;
   logic [31:0] a_mag, b_mag;
   logic [32:0] part, diff;
   logic [31:0] quo, rem;

   assign is_sdiv = (aluop_i == OP_DIV);
   assign is_div  = is_sdiv || (aluop_i == OP_DIVU);
   assign is_mt   = (aluop_i == OP_MTHI) || (aluop_i == OP_MTLO);
   assign a_mag   = (is_sdiv && reg1_i[31]) ? -reg1_i : reg1_i;
   assign b_mag   = (is_sdiv && reg2_i[31]) ? -reg2_i : reg2_i;
   assign part    = acc_q[63:31];
   assign diff    = part - {1'b0, dvsr_q};
   assign quo     = acc_q[31:0];
   assign rem     = acc_q[63:32];

   // Result mux for the current operation
   always_comb begin
      result = '0;
      unique case (alusel_i)
         SEL_LOGIC: begin
            case (aluop_i)
               OP_AND:  result = reg1_i & reg2_i;
               OP_OR:   result = reg1_i | reg2_i;
               OP_XOR:  result = reg1_i ^ reg2_i;
               OP_NOR:  result = ~(reg1_i | reg2_i);
               default: result = '0;
            endcase
         end
         SEL_SHIFT: begin
            case (aluop_i)
               OP_SLL:  result = reg2_i << reg1_i[4:0];
               OP_SRL:  result = reg2_i >> reg1_i[4:0];
               OP_SRA:  result = 32'($signed(reg2_i) >>> reg1_i[4:0]);
               default: result = '0;
            endcase
         end
         SEL_MOVE: begin
            case (aluop_i)
               OP_MFHI: result = hi_q;
               OP_MFLO: result = lo_q;
               default: result = '0;
            endcase
         end
         default: result = '0;
      endcase
   end

   // Divider next state, stall request and HI/LO updates
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      dvsr_d  = dvsr_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      stall   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (is_div) begin
               if (reg2_i != '0) begin
                  stall   = 1'b1;
                  acc_d   = {32'b0, a_mag};
                  dvsr_d  = b_mag;
                  negq_d  = is_sdiv & (reg1_i[31] ^ reg2_i[31]);
                  negr_d  = is_sdiv & reg1_i[31];
                  cnt_d   = '0;
                  state_d = S_BUSY;
               end else begin
                  lo_d = '1;
                  hi_d = reg1_i;
               end
            end else if (aluop_i == OP_MTHI) begin
               hi_d = reg1_i;
            end else if (aluop_i == OP_MTLO) begin
               lo_d = reg1_i;
            end
         end
         S_BUSY: begin
            stall = 1'b1;
            if (!diff[32]) begin
               acc_d = {diff[31:0], acc_q[30:0], 1'b1};
            end else begin
               acc_d = {part[31:0], acc_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(DIV_CYCLES - 1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            lo_d    = negq_q ? -quo : quo;
            hi_d    = negr_q ? -rem : rem;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Divider and HI/LO state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         dvsr_q  <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         dvsr_q  <= dvsr_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // EX/MEM register; a stalled cycle inserts a bubble
   always_ff @(posedge clk) begin
      if (rst || stall) begin
         wreg_q  <= 1'b0;
         wd_q    <= '0;
         wdata_q <= '0;
      end else begin
         wreg_q  <= fwd_wreg_o;
         wd_q    <= fwd_wd_o;
         wdata_q <= fwd_wdata_o;
      end
   end

   assign fwd_wreg_o  = wreg_i & ~stall & ~is_mt;
   assign fwd_wd_o    = wd_i;
   assign fwd_wdata_o = result;
   assign wreg_o      = wreg_q;
   assign wd_o        = wd_q;
   assign wdata_o     = wdata_q;
   assign hi_o        = hi_q;
   assign lo_o        = lo_q;
   assign stall_req_o = stall;

endmodule

// File: tb/tb_ex_hilo_div_stage.sv
// Directed bench for ex_hilo_div_stage: ALU vector table,
// HI/LO moves, divider latency/results, divide by zero, reset abort.
module tb_ex_hilo_div_stage;

   localparam logic [7:0] OP_NOP  = 8'b00000000;
   localparam logic [7:0] OP_AND  = 8'b00100100;
   localparam logic [7:0] OP_OR   = 8'b00100101;
   localparam logic [7:0] OP_XOR  = 8'b00100110;
   localparam logic [7:0] OP_NOR  = 8'b00100111;
   localparam logic [7:0] OP_SLL  = 8'b01111100;
   localparam logic [7:0] OP_SRL  = 8'b00000010;
   localparam logic [7:0] OP_SRA  = 8'b00000011;
   localparam logic [7:0] OP_MFHI = 8'b00010000;
   localparam logic [7:0] OP_MTHI = 8'b00010001;
   localparam logic [7:0] OP_MFLO = 8'b00010010;
   localparam logic [7:0] OP_MTLO = 8'b00010011;
   localparam logic [7:0] OP_DIV  = 8'b00011010;
   localparam logic [7:0] OP_DIVU = 8'b00011011;

   localparam logic [2:0] SEL_NOP   = 3'b000;
   localparam logic [2:0] SEL_LOGIC = 3'b001;
   localparam logic [2:0] SEL_SHIFT = 3'b010;
   localparam logic [2:0] SEL_MOVE  = 3'b011;

   logic        clk;
   logic        rst;
   logic [7:0]  aluop_i;
   logic [2:0]  alusel_i;
   logic [31:0] reg1_i;
   logic [31:0] reg2_i;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic        fwd_wreg_o;
   logic [4:0]  fwd_wd_o;
   logic [31:0] fwd_wdata_o;
   logic        wreg_o;
   logic [4:0]  wd_o;
   logic [31:0] wdata_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic        stall_req_o;

   int checks = 0;
   int errors = 0;

   ex_hilo_div_stage dut (
      .clk         (clk),
      .rst         (rst),
      .aluop_i     (aluop_i),
      .alusel_i    (alusel_i),
      .reg1_i      (reg1_i),
      .reg2_i      (reg2_i),
      .wd_i        (wd_i),
      .wreg_i      (wreg_i),
      .fwd_wreg_o  (fwd_wreg_o),
      .fwd_wd_o    (fwd_wd_o),
      .fwd_wdata_o (fwd_wdata_o),
      .wreg_o      (wreg_o),
      .wd_o        (wd_o),
      .wdata_o     (wdata_o),
      .hi_o        (hi_o),
      .lo_o        (lo_o),
      .stall_req_o (stall_req_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  op;
      logic [2:0]  sel;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] exp_data;
      logic        exp_wreg;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic [4:0] wd, input logic wr);
      aluop_i  = op;
      alusel_i = sel;
      reg1_i   = r1;
      reg2_i   = r2;
      wd_i     = wd;
      wreg_i   = wr;
   endtask

   task automatic run_div(input string nm, input logic [7:0] op,
                          input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi);
      int n;
      int bad;
      n   = 0;
      bad = 0;
      drive(op, SEL_NOP, r1, r2, 5'd9, 1'b1);
      #1;
      chk({nm, "_issue_stall"}, 32'(stall_req_o), 32'd1);
      chk({nm, "_issue_fwd_wreg"}, 32'(fwd_wreg_o), 32'd0);
      while (stall_req_o && n < 100) begin
         n++;
         step();
         if (wreg_o !== 1'b0 || wd_o !== 5'd0 || wdata_o !== 32'd0)
            bad++;
      end
      chk({nm, "_stall_cycles"}, 32'(n), 32'd33);
      chk({nm, "_bubbles"}, 32'(bad), 32'd0);
      step();
      drive(OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
      chk({nm, "_lo"}, lo_o, exp_lo);
      chk({nm, "_hi"}, hi_o, exp_hi);
      #1;
      chk({nm, "_after_stall"}, 32'(stall_req_o), 32'd0);
   endtask

   initial begin
      vecs[0] = '{OP_OR,   SEL_LOGIC, 32'h0000F0F0, 32'h00FF0000, 5'd3,  1'b1,
                  32'h00FFF0F0, 1'b1};
      vecs[1] = '{OP_SRA,  SEL_SHIFT, 32'd4,        32'h80000010, 5'd4,  1'b1,
                  32'hF8000001, 1'b1};
      vecs[2] = '{OP_NOR,  SEL_LOGIC, 32'h0,        32'h0,        5'd6,  1'b1,
                  32'hFFFFFFFF, 1'b1};
      vecs[3] = '{OP_AND,  SEL_LOGIC, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd7,  1'b1,
                  32'h00F000F0, 1'b1};
      vecs[4] = '{OP_XOR,  SEL_LOGIC, 32'hFFFF0000, 32'h0F0F0F0F, 5'd8,  1'b1,
                  32'hF0F00F0F, 1'b1};
      vecs[5] = '{OP_SLL,  SEL_SHIFT, 32'd31,       32'h00000001, 5'd10, 1'b1,
                  32'h80000000, 1'b1};
      vecs[6] = '{OP_SRL,  SEL_SHIFT, 32'd4,        32'h80000010, 5'd11, 1'b1,
                  32'h08000001, 1'b1};
      vecs[7] = '{OP_SLL,  SEL_SHIFT, 32'h00000024, 32'h00000001, 5'd12, 1'b1,
                  32'h00000010, 1'b1};
      vecs[8] = '{OP_SLL,  SEL_LOGIC, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 1'b1,
                  32'h00000000, 1'b1};
      vecs[9] = '{OP_OR,   SEL_LOGIC, 32'h12340000, 32'h00005678, 5'd14, 1'b0,
                  32'h12345678, 1'b0};

      rst = 1'b1;
      drive(OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
      step();
      step();
      rst = 1'b0;
      chk("rst_hi", hi_o, 32'd0);
      chk("rst_lo", lo_o, 32'd0);
      chk("rst_wreg", 32'(wreg_o), 32'd0);
      chk("rst_wd", 32'(wd_o), 32'd0);
      chk("rst_wdata", wdata_o, 32'd0);
      chk("rst_stall", 32'(stall_req_o), 32'd0);

      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].op, vecs[i].sel, vecs[i].r1, vecs[i].r2,
               vecs[i].wd, vecs[i].wreg);
         #1;
         chk($sformatf("vec%0d_fwd_wdata", i), fwd_wdata_o, vecs[i].exp_data);
         chk($sformatf("vec%0d_fwd_wreg", i), 32'(fwd_wreg_o),
             32'(vecs[i].exp_wreg));
         step();
         chk($sformatf("vec%0d_wdata", i), wdata_o, vecs[i].exp_data);
         chk($sformatf("vec%0d_wd", i), 32'(wd_o), 32'(vecs[i].wd));
         chk($sformatf("vec%0d_wreg", i), 32'(wreg_o), 32'(vecs[i].exp_wreg));
      end

      drive(OP_MTLO, SEL_NOP, 32'h12345678, 32'd0, 5'd2, 1'b1);
      #1;
      chk("mtlo_fwd_wreg", 32'(fwd_wreg_o), 32'd0);
      step();
      chk("mtlo_wreg", 32'(wreg_o), 32'd0);
      chk("mtlo_lo", lo_o, 32'h12345678);
      drive(OP_MFLO, SEL_MOVE, 32'd0, 32'd0, 5'd5, 1'b1);
      #1;
      chk("mflo_fwd", fwd_wdata_o, 32'h12345678);
      step();
      chk("mflo_wdata", wdata_o, 32'h12345678);
      chk("mflo_wd", 32'(wd_o), 32'd5);
      chk("mflo_wreg", 32'(wreg_o), 32'd1);
      drive(OP_MTHI, SEL_NOP, 32'hCAFEF00D, 32'd0, 5'd0, 1'b0);
      step();
      chk("mthi_hi", hi_o, 32'hCAFEF00D);
      chk("mthi_lo_kept", lo_o, 32'h12345678);
      drive(OP_MFHI, SEL_MOVE, 32'd0, 32'd0, 5'd6, 1'b1);
      step();
      chk("mfhi_wdata", wdata_o, 32'hCAFEF00D);

      run_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2);
      run_div("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2,
              32'hFFFFFFFD, 32'hFFFFFFFF);
      run_div("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE,
              32'hFFFFFFFD, 32'd1);
      run_div("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF,
              32'h80000000, 32'd0);

      drive(OP_DIV, SEL_NOP, 32'h55, 32'd0, 5'd0, 1'b0);
      #1;
      chk("div0_stall", 32'(stall_req_o), 32'd0);
      step();
      drive(OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
      chk("div0_lo", lo_o, 32'hFFFFFFFF);
      chk("div0_hi", hi_o, 32'h55);

      drive(OP_DIVU, SEL_NOP, 32'd1000, 32'd3, 5'd0, 1'b0);
      step();
      for (int i = 0; i < 10; i++) step();
      chk("abort_busy_stall", 32'(stall_req_o), 32'd1);
      rst = 1'b1;
      drive(OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
      step();
      rst = 1'b0;
      #1;
      chk("abort_stall", 32'(stall_req_o), 32'd0);
      chk("abort_hi", hi_o, 32'd0);
      chk("abort_lo", lo_o, 32'd0);
      step();
      run_div("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
